// File: rtl/matmul_engine_if.sv
// rtl/matmul_engine_if.sv - host load/readback and start/busy/done port bundle for matmul_engine
// Optional ovf signal exists only when MATMUL_SATURATE_EN is defined.
interface matmul_engine_if #(
  parameter int N  = 4,
  parameter int DW = 32
);
  localparam int LOGN = $clog2(N);
  localparam int AW   = 2 + 2 * LOGN;

  logic          we;
  logic [AW-1:0] writeAddr;
  logic [DW-1:0] writeData;
  logic [AW-1:0] readAddr;
  logic [DW-1:0] readData;
  logic          start;
  logic          busy;
  logic          done;
`ifdef MATMUL_SATURATE_EN
  logic          ovf;

  modport master (output we, writeAddr, writeData, readAddr, start,
                  input  readData, busy, done, ovf);
  modport slave  (input  we, writeAddr, writeData, readAddr, start,
                  output readData, busy, done, ovf);
`else
  modport master (output we, writeAddr, writeData, readAddr, start,
                  input  readData, busy, done);
  modport slave  (input  we, writeAddr, writeData, readAddr, start,
                  output readData, busy, done);
`endif
endinterface

// File: rtl/matmul_engine.sv
// rtl/matmul_engine.sv - sequential NxN signed matrix multiplier, N MACs, one row of C per N cycles
// Define MATMUL_SATURATE_EN for saturating arithmetic with a sticky ovf flag.
module matmul_engine #(
  parameter int N  = 4,
  parameter int DW = 32
) (
  input logic            clk,
  input logic            reset,
  matmul_engine_if.slave bus
);
  localparam int LOGN = $clog2(N);
  localparam int AW   = 2 + 2 * LOGN;

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  logic signed [DW-1:0] a   [N][N];
  logic signed [DW-1:0] b   [N][N];
  logic signed [DW-1:0] c   [N][N];
  logic signed [DW-1:0] acc [N];
  logic signed [DW-1:0] s   [N];

  state_t          state;
  logic [LOGN-1:0] i;
  logic [LOGN-1:0] k;
  logic            busy_q;
  logic            done_q;
  logic [DW-1:0]   read_q;
  logic [DW-1:0]   rd_mux;

  logic [1:0]      wbank, rbank;
  logic [LOGN-1:0] wrow, wcol, rrow, rcol;

  assign wbank = bus.writeAddr[AW-1:AW-2];
  assign wrow  = bus.writeAddr[2*LOGN-1:LOGN];
  assign wcol  = bus.writeAddr[LOGN-1:0];
  assign rbank = bus.readAddr[AW-1:AW-2];
  assign rrow  = bus.readAddr[2*LOGN-1:LOGN];
  assign rcol  = bus.readAddr[LOGN-1:0];

  always_comb begin
    rd_mux = '0;
    case (rbank)
      2'd0:    rd_mux = a[rrow][rcol];
      2'd1:    rd_mux = b[rrow][rcol];
      2'd2:    rd_mux = c[rrow][rcol];
      default: rd_mux = '0;
    endcase
  end

`ifdef MATMUL_SATURATE_EN
  localparam logic signed [DW-1:0]   SMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0]   SMIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [2*DW-1:0] PMAX = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [2*DW-1:0] PMIN = {{(DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [2*DW-1:0] p_full;
  logic signed [DW-1:0]   p;
  logic signed [DW:0]     s_full;
  logic signed [DW-1:0]   acc_in;
  logic                   clamp;
  logic                   ovf_q;

  assign bus.ovf = ovf_q;

  // Clamp the full-width product first, then clamp the DW+1 bit sum.
  always_comb begin
    p_full = '0;
    p      = '0;
    s_full = '0;
    acc_in = '0;
    clamp  = 1'b0;
    for (int j = 0; j < N; j++) begin
      acc_in = (k == '0) ? '0 : acc[j];
      p_full = a[i][k] * b[k][j];
      if (p_full > PMAX) begin
        p     = SMAX;
        clamp = 1'b1;
      end else if (p_full < PMIN) begin
        p     = SMIN;
        clamp = 1'b1;
      end else begin
        p = p_full[DW-1:0];
      end
      s_full = {acc_in[DW-1], acc_in} + {p[DW-1], p};
      if (s_full[DW] != s_full[DW-1]) begin
        s[j]  = s_full[DW] ? SMIN : SMAX;
        clamp = 1'b1;
      end else begin
        s[j] = s_full[DW-1:0];
      end
    end
  end
`else
  always_comb begin
    for (int j = 0; j < N; j++) begin
      s[j] = ((k == '0) ? '0 : acc[j]) + a[i][k] * b[k][j];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      read_q <= '0;
      i      <= '0;
      k      <= '0;
`ifdef MATMUL_SATURATE_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      read_q <= rd_mux;
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.we && wbank == 2'd0) a[wrow][wcol] <= bus.writeData;
          if (bus.we && wbank == 2'd1) b[wrow][wcol] <= bus.writeData;
          if (bus.start) begin
            state  <= COMPUTE;
            busy_q <= 1'b1;
            i      <= '0;
            k      <= '0;
`ifdef MATMUL_SATURATE_EN
            ovf_q  <= 1'b0;
`endif
          end
        end
        COMPUTE: begin
          for (int j = 0; j < N; j++) acc[j] <= s[j];
`ifdef MATMUL_SATURATE_EN
          if (clamp) ovf_q <= 1'b1;
`endif
          if (k == LOGN'(N - 1)) begin
            for (int j = 0; j < N; j++) c[i][j] <= s[j];
            k <= '0;
            i <= i + 1'b1;
            if (i == LOGN'(N - 1)) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end else begin
            k <= k + 1'b1;
          end
        end
        default: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.readData = read_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
endmodule
